// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue sequencer: MIPS opcode/funct
// constants, the FPU control code enum, latency class select and the
// sequencer state enum.
package fpu_pkg;

    localparam logic [5:0] OP_FTYPE = 6'b010001;
    localparam logic [5:0] OP_LWC1  = 6'b110001;
    localparam logic [5:0] OP_SWC1  = 6'b111001;

    localparam logic [5:0] FN_ADD = 6'b000000;
    localparam logic [5:0] FN_SUB = 6'b000001;
    localparam logic [5:0] FN_MUL = 6'b000010;
    localparam logic [5:0] FN_DIV = 6'b000011;
    localparam logic [5:0] FN_ABS = 6'b000101;
    localparam logic [5:0] FN_NEG = 6'b000111;

    typedef enum logic [3:0] {
        FPU_ADD = 4'b0000,
        FPU_SUB = 4'b0001,
        FPU_MUL = 4'b0010,
        FPU_DIV = 4'b0011,
        FPU_ABS = 4'b0100,
        FPU_NEG = 4'b0101
    } fpu_op_t;

    typedef enum logic [1:0] {
        LAT_SEL_ADD    = 2'b00,
        LAT_SEL_MUL    = 2'b01,
        LAT_SEL_DIV    = 2'b10,
        LAT_SEL_SIMPLE = 2'b11
    } lat_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

endpackage

// File: rtl/fpu_funct_dec.sv
// Combinational decode of the F-type funct field.
// Ports:
//   funct_i   : funct field of the ID instruction
//   legal_o   : funct is a supported FPU operation
//   op_o      : FPU control code (FPU_ADD when illegal)
//   lat_sel_o : latency class of the operation
module fpu_funct_dec
    import fpu_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic       legal_o,
    output fpu_op_t    op_o,
    output lat_sel_t   lat_sel_o
);

    // funct -> {legal, control code, latency class}
    always_comb begin
        legal_o   = 1'b1;
        op_o      = FPU_ADD;
        lat_sel_o = LAT_SEL_ADD;
        case (funct_i)
            FN_ADD: begin op_o = FPU_ADD; lat_sel_o = LAT_SEL_ADD;    end
            FN_SUB: begin op_o = FPU_SUB; lat_sel_o = LAT_SEL_ADD;    end
            FN_MUL: begin op_o = FPU_MUL; lat_sel_o = LAT_SEL_MUL;    end
            FN_DIV: begin op_o = FPU_DIV; lat_sel_o = LAT_SEL_DIV;    end
            FN_ABS: begin op_o = FPU_ABS; lat_sel_o = LAT_SEL_SIMPLE; end
            FN_NEG: begin op_o = FPU_NEG; lat_sel_o = LAT_SEL_SIMPLE; end
            default: begin
                legal_o   = 1'b0;
                op_o      = FPU_ADD;
                lat_sel_o = LAT_SEL_ADD;
            end
        endcase
    end

endmodule

// File: rtl/fpu_issue_seq.sv
// Multi-cycle issue sequencer for the single non-pipelined FPU.
// Issues F-type instructions from ID, strobes fpu_start, counts the
// operation latency, stalls ID on structural and FP-register hazards and
// arbitrates the FP register-file write port against lwc1 (mem_fp_wb wins).
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   id_valid, op, funct   : ID instruction
//   fs, ft, fd            : ID FP register fields
//   id_stall              : stall ID/IF (combinational)
//   fpu_start             : one-cycle strobe on first EXEC cycle
//   fpu_control           : latched FPU operation code
//   mem_fp_wb             : lwc1 owns the write port this cycle
//   fp_wb_en, fp_wb_reg   : FPU result write-back
//   busy                  : sequencer not idle
//   illegal               : F-type with unsupported funct (combinational)
module fpu_issue_seq
    import fpu_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int LAT_ADD    = 2,
    parameter int LAT_MUL    = 4,
    parameter int LAT_DIV    = 12,
    parameter int LAT_SIMPLE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] fs,
    input  logic [REG_AW-1:0] ft,
    input  logic [REG_AW-1:0] fd,
    output logic              id_stall,
    output logic              fpu_start,
    output logic [3:0]        fpu_control,
    input  logic              mem_fp_wb,
    output logic              fp_wb_en,
    output logic [REG_AW-1:0] fp_wb_reg,
    output logic              busy,
    output logic              illegal
);

    localparam int MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int MAX_DS  = (LAT_DIV > LAT_SIMPLE) ? LAT_DIV : LAT_SIMPLE;
    localparam int MAX_LAT = (MAX_AM > MAX_DS) ? MAX_AM : MAX_DS;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_AW-1:0]   pend_fd_q, pend_fd_d;
    fpu_op_t             ctrl_q, ctrl_d;
    logic                start_q, start_d;

    logic                dec_legal_s;
    fpu_op_t             dec_op_s;
    lat_sel_t            dec_lat_sel_s;
    logic [CNT_W-1:0]    lat_m1_s;
    logic                wb_accept_s;
    logic                pending_s;
    logic                legal_f_s;
    logic                f_raw_s;
    logic                mem_raw_s;
    logic                issue_s;

    fpu_funct_dec u_dec (
        .funct_i   (funct),
        .legal_o   (dec_legal_s),
        .op_o      (dec_op_s),
        .lat_sel_o (dec_lat_sel_s)
    );

    // Counter preload value: latency minus one of the decoded operation
    always_comb begin
        lat_m1_s = {CNT_W{1'b0}};
        case (dec_lat_sel_s)
            LAT_SEL_ADD:    lat_m1_s = CNT_W'(LAT_ADD - 1);
            LAT_SEL_MUL:    lat_m1_s = CNT_W'(LAT_MUL - 1);
            LAT_SEL_DIV:    lat_m1_s = CNT_W'(LAT_DIV - 1);
            LAT_SEL_SIMPLE: lat_m1_s = CNT_W'(LAT_SIMPLE - 1);
            default:        lat_m1_s = {CNT_W{1'b0}};
        endcase
    end

    // A WB cycle that loses the port to lwc1 still counts as pending; an
    // accepted WB does not, since the write lands on the falling edge and
    // a reader in this cycle sees the new value.
    assign wb_accept_s = (state_q == ST_WB) && !mem_fp_wb;
    assign pending_s   = (state_q == ST_EXEC) || ((state_q == ST_WB) && mem_fp_wb);
    assign legal_f_s   = (op == OP_FTYPE) && dec_legal_s;
    assign f_raw_s     = legal_f_s && pending_s &&
                         ((fs == pend_fd_q) || (ft == pend_fd_q) || (fd == pend_fd_q));
    assign mem_raw_s   = ((op == OP_LWC1) || (op == OP_SWC1)) && pending_s &&
                         (ft == pend_fd_q);

    assign id_stall = id_valid && ((legal_f_s && pending_s) || f_raw_s || mem_raw_s);
    // Stall already covers every pending state, so a non-stalled legal
    // F-type is always in IDLE or in an accepting WB cycle.
    assign issue_s  = id_valid && legal_f_s && !id_stall;
    assign illegal  = id_valid && (op == OP_FTYPE) && !dec_legal_s;

    // Next-state, counter and issue latches
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_fd_d = pend_fd_q;
        ctrl_d    = ctrl_q;
        start_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) state_d = ST_EXEC;
                else         state_d = ST_IDLE;
            end
            ST_EXEC: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB: begin
                if (wb_accept_s) begin
                    if (issue_s) state_d = ST_EXEC;
                    else         state_d = ST_IDLE;
                end else begin
                    state_d = ST_WB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue_s) begin
            cnt_d     = lat_m1_s;
            pend_fd_d = fd;
            ctrl_d    = dec_op_s;
            start_d   = 1'b1;
        end else begin
            start_d   = 1'b0;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            pend_fd_q <= {REG_AW{1'b0}};
            ctrl_q    <= FPU_ADD;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_fd_q <= pend_fd_d;
            ctrl_q    <= ctrl_d;
            start_q   <= start_d;
        end
    end

    assign fpu_start   = start_q;
    assign fpu_control = ctrl_q;
    assign fp_wb_en    = wb_accept_s;
    assign fp_wb_reg   = pend_fd_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
